// File: rtl/moore_seq_det_param.sv
// -----------------------------------------------------------------------------
// moore_seq_det_param
// Parametrised Moore serial sequence detector with a saturating match counter.
//
// The FSM state is the number of pattern bits currently matched (0..SEQ_LEN).
// State SEQ_LEN is the detect state DET. Next-state values come from a table
// that is built at elaboration with a KMP-style fallback. Because of this, a
// partial mismatch still keeps the longest prefix of the pattern that is
// already matched.
//
// Parameters
//   SEQ_LEN : pattern length N, 2..16
//   PATTERN : N-bit pattern, MSB is the first bit received
//   OVERLAP : 0 = restart from scratch after DET, 1 = reuse the pattern border
//   CNT_W   : match counter width, 1..32
//
// Ports
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   s_in      : serial data bit, sampled when en=1
//   en        : sample enable; en=0 holds all state
//   clr_cnt   : synchronous clear of match_cnt (has priority over an increment)
//   s_out     : detect flag, high while the FSM is in DET
//   match_cnt : saturating count of detections
//   cs, ns    : current / next state (only present with SEQ_DET_DBG_EN)
//
// Optional feature macro: SEQ_DET_DBG_EN (exposes the cs and ns debug ports)
// -----------------------------------------------------------------------------
module moore_seq_det_param #(
    parameter int                 SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] PATTERN = 4'b0110,
    parameter bit                 OVERLAP = 1'b0,
    parameter int                 CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_in,
    input  logic                        en,
    input  logic                        clr_cnt,
`ifdef SEQ_DET_DBG_EN
    output logic [$clog2(SEQ_LEN+1)-1:0] cs,
    output logic [$clog2(SEQ_LEN+1)-1:0] ns,
`endif
    output logic                        s_out,
    output logic [CNT_W-1:0]            match_cnt
);

    localparam int               SW      = $clog2(SEQ_LEN + 1);
    localparam logic [SW-1:0]    DET     = SW'(SEQ_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Elaboration-time range checks
    if (SEQ_LEN < 2 || SEQ_LEN > 16) begin : g_bad_seq_len
        $error("moore_seq_det_param: SEQ_LEN must be in 2..16");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("moore_seq_det_param: CNT_W must be in 1..32");
    end

    // Pattern bit P[idx]. P[0] is the first bit received, which is PATTERN[N-1].
    function automatic logic p_bit(input int idx);
        logic [SEQ_LEN-1:0] sh;
        sh = PATTERN >> (SEQ_LEN - 1 - idx);
        return sh[0];
    endfunction

    // delta(k,b) is the length of the longest prefix of P that is also a
    // suffix of P[0..k-1] followed by b. The result is capped at N.
    function automatic int delta_f(input int k, input int b);
        int   best;
        int   pos;
        logic ok;
        logic xb;
        best = 0;
        for (int j = 1; j <= SEQ_LEN; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int i = 0; i < SEQ_LEN; i++) begin
                    if (i < j) begin
                        pos = k + 1 - j + i;
                        if (pos == k) begin
                            xb = (b != 0);
                        end else begin
                            xb = p_bit(pos);
                        end
                        if (p_bit(i) != xb) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return best;
    endfunction

    // Next-state table, indexed by {state, s_in}. Without overlap, the DET row
    // restarts as if it were state 0.
    logic [SW-1:0] nxt_tbl [0:2*SEQ_LEN+1];

    for (genvar k = 0; k <= SEQ_LEN; k++) begin : g_row
        for (genvar b = 0; b < 2; b++) begin : g_col
            localparam int NXT = (k == SEQ_LEN && !OVERLAP) ? delta_f(0, b)
                                                            : delta_f(k, b);
            assign nxt_tbl[2*k+b] = SW'(NXT);
        end
    end

    logic [SW-1:0]    state_q;
    logic [SW-1:0]    state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= {SW{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-count logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (en) begin
            // An unreachable encoding above DET recovers to the idle state
            if (state_q <= DET) begin
                state_d = nxt_tbl[{state_q, s_in}];
            end else begin
                state_d = {SW{1'b0}};
            end
        end else begin
            state_d = state_q;
        end
        if (clr_cnt) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en && (state_d == DET) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output decode from registered state only
    always_comb begin
        s_out     = (state_q == DET);
        match_cnt = cnt_q;
    end

`ifdef SEQ_DET_DBG_EN
    // Debug view of the FSM
    always_comb begin
        cs = state_q;
        ns = state_d;
    end
`endif

endmodule

// File: doc/moore_seq_det_param.md
Name: moore_seq_det_param

Overview:
Parametrised Moore serial sequence detector. Generalises the fixed 4-bit non-overlapping 0110 detector to any pattern length and value, with selectable overlap mode. Adds a sample-enable input and a saturating match counter with synchronous clear. Sits on a single-bit serial input stream. Its registered detect flag feeds downstream control logic.

Parameters:
SEQ_LEN, 4, pattern length N in bits; legal range 2..16.
PATTERN, 4'b0110, SEQ_LEN-bit pattern; MSB is the first bit received.
OVERLAP, 0, 0 = non-overlapping detection, 1 = overlapping detection.
CNT_W, 8, width of match counter; legal range 1..32.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-low: rst=0 resets immediately, independent of clk.
s_in  input  1  serial data bit, sampled on a rising clk edge when en=1.
en  input  1  sample enable; en=0 holds all state.
clr_cnt  input  1  synchronous clear of match_cnt.
s_out  output  1  Moore detect flag; high only while FSM is in state DET.
match_cnt  output  CNT_W  number of detections, saturating.

Behaviour:
- State encoding: S = number of pattern bits currently matched, 0..N, in a register of width clog2(N+1). State N = DET.
- Pattern bit order: P[0] = PATTERN[N-1] (first received bit), P[N-1] = PATTERN[0].
- s_out = (state == N). It decodes registered state only and has no combinational path from s_in.
- Reset while rst=0: state=0, s_out=0, match_cnt=0. This takes effect asynchronously, including mid-pattern and while in DET. The first sample is taken on the first rising edge with rst=1 and en=1.
- Transition function delta(k,b): the longest prefix of P that is also a suffix of P[0..k-1] followed by b. Capped at N. This is a KMP fallback, so a partial mismatch never loses a valid restart (e.g. 0110 pattern, input 0 0 1 1 0 detects).
- From S<N with en=1: next = delta(S, s_in).
- From DET with en=1:
  - OVERLAP=0: next = delta(0, s_in), i.e. 1 if s_in==P[0], else 0.
  - OVERLAP=1: next = delta(N, s_in), the longest border of P followed by s_in. This may equal N, e.g. pattern 1111 followed by another 1 stays in DET.
- en=0: state and match_cnt hold. s_out holds its value, including high in DET.
- Latency: the last pattern bit is sampled on edge t, and s_out is high in the cycle after edge t. s_out stays high for exactly one cycle per detection when en stays high.
- match_cnt updates on a rising edge when en=1 and next state == N. It updates on the same edge s_out rises, or on the edge DET re-enters DET.
- match_cnt saturates at 2^CNT_W-1 and never wraps.
- clr_cnt=1 sets match_cnt=0 on the next edge regardless of en. On a simultaneous clr_cnt and increment, the clear wins (count = 0).
- The transition table is derived at elaboration (function or generate). The state register, next-state logic and output decode are kept as separate processes.
- Elaboration error if SEQ_LEN is out of range or CNT_W < 1.

Optional Feature:
Macro SEQ_DET_DBG_EN.
- Defined: adds output ports cs and ns, width clog2(SEQ_LEN+1). cs is the current state register; ns is the combinational next state (equals cs when en=0).
- Undefined: cs and ns ports are absent. Functional behaviour is otherwise identical.

Test Plan:
- Defaults (0110, OVERLAP=0), rst low for 2 cycles then high, en=1, s_in = 0,1,1,0,1,1,0 -> s_out high for one cycle after the 4th bit only; match_cnt=1.
- Same stream with OVERLAP=1 -> s_out high one cycle after the 4th and after the 7th bit; match_cnt=2.
- Defaults, stream 0,0,1,1,0 -> s_out high after the 5th bit, confirming the KMP fallback; stream 0,1,0,1,1,0 -> s_out high after the 6th bit.
- PATTERN=4'b1111, OVERLAP=1, six consecutive 1s -> s_out high for 3 consecutive cycles; match_cnt=3. With OVERLAP=0 -> s_out high once; match_cnt=1.
- Defaults: feed 0,1,1, then drop rst asynchronously mid-cycle, release, then feed 0 -> no detect; s_out=0 and match_cnt=0 immediately on rst=0. Separately, en=0 for 3 cycles between bits 2 and 3 of 0110 -> state holds and detect still occurs.
- CNT_W=2, defaults, 5 detections -> match_cnt reads 1,2,3,3,3. Then clr_cnt=1 on the edge of a 6th detection -> match_cnt=0 while s_out=1.
